// File: rtl/riscv_pkg.sv
// Shared constants and types for the MEM-stage data-memory initiator.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mau_state_e;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data = {24'b0, shifted[7:0]};
      F3_HU:   data = {16'b0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: runs one req/ack bus transaction per load/store and
// stalls upstream until the instruction can be handed to MEM/WB.
module mem_access_unit #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] NOP_INSN = riscv_pkg::NOP_INSN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        RegWrite_in,
  input  logic        MemToReg_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] instruction_in,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_data_out,
  output logic [4:0]  rd_out,
  output logic [31:0] instruction_out,
  output logic        stall_out,
  output logic        misaligned_out,
  output logic        bus_err_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  riscv_pkg::mau_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            regwrite_q, memtoreg_q, we_q;
  logic [31:0]     alu_q, insn_q, addr_q, wdata_q;
  logic [4:0]      rd_q;
  logic [2:0]      f3_q;
  logic [3:0]      be_q;

  logic        mem_op, illegal, misaligned, start;
  logic [1:0]  off;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, ext_data;

  assign off    = alu_result_in[1:0];
  assign mem_op = valid_in & (MemRead_in | MemWrite_in);
  assign start  = (state_q == riscv_pkg::StIdle) & mem_op & ~illegal & ~misaligned;

  // Legality, alignment and lane placement of the incoming EX/MEM access.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    be_d       = 4'b1111;
    wdata_d    = '0;
    if (MemWrite_in) begin
      illegal = funct3_in[2] | (funct3_in[1:0] == 2'b11);
    end else begin
      illegal = (funct3_in == 3'b011) | (funct3_in[2:1] == 2'b11);
    end
    case (funct3_in[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
    if (MemWrite_in) begin
      case (funct3_in[1:0])
        2'b00: begin
          be_d    = 4'b0001 << off;
          wdata_d = {4{store_data_in[7:0]}};
        end
        2'b01: begin
          be_d    = 4'b0011 << off;
          wdata_d = {2{store_data_in[15:0]}};
        end
        default: wdata_d = store_data_in;
      endcase
    end
  end

  load_extend u_load_extend (
    .rdata  (rdata_q),
    .off    (alu_q[1:0]),
    .funct3 (f3_q),
    .data   (ext_data)
  );

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    err_d           = err_q;
    rdata_d         = rdata_q;
    RegWrite_out    = 1'b0;
    MemToReg_out    = 1'b0;
    alu_result_out  = '0;
    mem_data_out    = '0;
    rd_out          = '0;
    instruction_out = NOP_INSN;
    stall_out       = 1'b0;
    misaligned_out  = 1'b0;
    bus_err_out     = 1'b0;
    unique case (state_q)
      riscv_pkg::StIdle: begin
        if (mem_op) begin
          if (illegal || misaligned) begin
            misaligned_out = 1'b1;
          end else begin
            stall_out = 1'b1;
            state_d   = riscv_pkg::StBusy;
            cnt_d     = '0;
            err_d     = 1'b0;
          end
        end else if (valid_in) begin
          RegWrite_out    = RegWrite_in;
          MemToReg_out    = MemToReg_in;
          alu_result_out  = alu_result_in;
          rd_out          = rd_in;
          instruction_out = instruction_in;
        end
      end
      riscv_pkg::StBusy: begin
        stall_out = 1'b1;
        cnt_d     = cnt_q + CntW'(1);
        // Ack is checked first so it wins over a same-cycle timeout.
        if (dmem_ack) begin
          rdata_d = dmem_rdata;
          state_d = riscv_pkg::StDone;
        end else if (cnt_q == CntMax) begin
          err_d   = 1'b1;
          state_d = riscv_pkg::StDone;
        end
      end
      riscv_pkg::StDone: begin
        RegWrite_out    = regwrite_q & ~err_q;
        MemToReg_out    = memtoreg_q;
        alu_result_out  = alu_q;
        mem_data_out    = (we_q | err_q) ? '0 : ext_data;
        rd_out          = rd_q;
        instruction_out = insn_q;
        bus_err_out     = err_q;
        state_d         = riscv_pkg::StIdle;
      end
      default: state_d = riscv_pkg::StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= riscv_pkg::StIdle;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      we_q       <= 1'b0;
      alu_q      <= '0;
      insn_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      f3_q       <= '0;
      be_q       <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (start) begin
        regwrite_q <= RegWrite_in;
        memtoreg_q <= MemToReg_in;
        we_q       <= MemWrite_in;
        alu_q      <= alu_result_in;
        insn_q     <= instruction_in;
        addr_q     <= {alu_result_in[31:2], 2'b00};
        wdata_q    <= wdata_d;
        rd_q       <= rd_in;
        f3_q       <= funct3_in;
        be_q       <= be_d;
      end
    end
  end

  assign dmem_req   = (state_q == riscv_pkg::StBusy);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected MEM/WB results are queued at issue
// and compared when the unit presents the completed instruction.
module tb_mem_access_unit;

  logic        clk, rst_n;
  logic        valid_in, MemRead_in, MemWrite_in, RegWrite_in, MemToReg_in;
  logic [2:0]  funct3_in;
  logic [31:0] alu_result_in, store_data_in, instruction_in;
  logic [4:0]  rd_in;
  logic        RegWrite_out, MemToReg_out;
  logic [31:0] alu_result_out, mem_data_out, instruction_out;
  logic [4:0]  rd_out;
  logic        stall_out, misaligned_out, bus_err_out;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic [31:0] alu;
    logic [31:0] md;
    logic [4:0]  rd;
    logic [31:0] insn;
  } res_t;

  res_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [31:0] Nop = 32'h0000_0013;

  mem_access_unit #(
    .TIMEOUT  (16),
    .NOP_INSN (32'h0000_0013)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_in        (valid_in),
    .MemRead_in      (MemRead_in),
    .MemWrite_in     (MemWrite_in),
    .RegWrite_in     (RegWrite_in),
    .MemToReg_in     (MemToReg_in),
    .funct3_in       (funct3_in),
    .alu_result_in   (alu_result_in),
    .store_data_in   (store_data_in),
    .rd_in           (rd_in),
    .instruction_in  (instruction_in),
    .RegWrite_out    (RegWrite_out),
    .MemToReg_out    (MemToReg_out),
    .alu_result_out  (alu_result_out),
    .mem_data_out    (mem_data_out),
    .rd_out          (rd_out),
    .instruction_out (instruction_out),
    .stall_out       (stall_out),
    .misaligned_out  (misaligned_out),
    .bus_err_out     (bus_err_out),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_be         (dmem_be),
    .dmem_wdata      (dmem_wdata),
    .dmem_rdata      (dmem_rdata),
    .dmem_ack        (dmem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t observe();
    res_t r;
    r = {RegWrite_out, MemToReg_out, alu_result_out, mem_data_out, rd_out, instruction_out};
    return r;
  endfunction

  // Reference result of a completed memory instruction.
  function automatic res_t model(input logic mr, input logic rw, input logic m2r,
                                 input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [4:0] rd, input logic [31:0] insn,
                                 input logic [31:0] rdata, input logic berr);
    res_t r;
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[8*addr[1:0] +: 8];
    h = rdata[16*addr[1] +: 16];
    r.rw = rw & ~berr;
    r.m2r = m2r;
    r.alu = addr;
    r.rd = rd;
    r.insn = insn;
    r.md = 32'h0;
    if (mr && !berr) begin
      case (f3)
        3'b000:  r.md = {{24{b[7]}}, b};
        3'b100:  r.md = {24'h0, b};
        3'b001:  r.md = {{16{h[15]}}, h};
        3'b101:  r.md = {16'h0, h};
        default: r.md = rdata;
      endcase
    end
    return r;
  endfunction

  task automatic set_inputs(input logic v, input logic mr, input logic mw, input logic rw,
                            input logic m2r, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sd, input logic [4:0] rd, input logic [31:0] insn);
    valid_in = v; MemRead_in = mr; MemWrite_in = mw; RegWrite_in = rw; MemToReg_in = m2r;
    funct3_in = f3; alu_result_in = addr; store_data_in = sd; rd_in = rd; instruction_in = insn;
  endtask

  task automatic clear_inputs();
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0, 5'd0, 32'h0);
  endtask

  // Drives one transaction from its IDLE cycle to the DONE cycle (ack_delay 0 = never ack).
  // Returns at posedge+1 after the DONE cycle with the inputs still held.
  task automatic wait_done(input int ack_delay, input logic [31:0] rdata,
                           output int stalls, output res_t obs, output logic berr,
                           output logic ok, output logic [31:0] b_addr, output logic [3:0] b_be,
                           output logic b_we, output logic [31:0] b_wdata, output logic stable);
    int busy;
    busy = 0; stalls = 0; ok = 1'b0; stable = 1'b1; berr = 1'b0; obs = '0;
    b_addr = '0; b_be = '0; b_we = 1'b0; b_wdata = '0;
    dmem_rdata = rdata;
    for (int c = 0; c < 64; c++) begin
      if (dmem_req) begin
        busy++;
        if (busy == 1) begin
          b_addr = dmem_addr; b_be = dmem_be; b_we = dmem_we; b_wdata = dmem_wdata;
        end else if (dmem_addr !== b_addr || dmem_be !== b_be || dmem_we !== b_we ||
                     dmem_wdata !== b_wdata) begin
          stable = 1'b0;
        end
        dmem_ack = (ack_delay > 0) && (busy == ack_delay);
      end
      @(negedge clk);
      if (stall_out) stalls++;
      else begin
        obs = observe(); berr = bus_err_out; ok = 1'b1;
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      if (ok) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    dmem_ack = 1'b0; dmem_rdata = '0;
    #3;
    n_checks++; if (dmem_req !== 1'b0) $display("FAIL rst_req got %b exp 0", dmem_req); else n_pass++;
    n_checks++; if ({dmem_we, dmem_be, dmem_addr, dmem_wdata} !== 69'h0)
      $display("FAIL rst_dmem got %b/%h/%h/%h exp 0", dmem_we, dmem_be, dmem_addr, dmem_wdata);
    else n_pass++;
    n_checks++; if (observe() !== {2'b00, 69'h0, Nop})
      $display("FAIL rst_bubble got %h exp %h", observe(), {2'b00, 69'h0, Nop});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    set_inputs(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 5'd3, 32'h1234_5003);
    @(posedge clk); #1;
    n_checks++; if (dmem_req !== 1'b1) $display("FAIL busy_req got %b exp 1", dmem_req); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (dmem_req !== 1'b0) $display("FAIL async_rst_req got %b exp 0", dmem_req); else n_pass++;
    n_checks++; if (dmem_addr !== 32'h0) $display("FAIL async_rst_addr got %h exp 0", dmem_addr); else n_pass++;
    n_checks++; if (instruction_out !== Nop)
      $display("FAIL async_rst_insn got %h exp %h", instruction_out, Nop);
    else n_pass++;
    clear_inputs();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if ({dmem_req, stall_out} !== 2'b00)
      $display("FAIL post_rst_idle got req/stall %b exp 00", {dmem_req, stall_out});
    else n_pass++;
  endtask

  task automatic test_add();
    res_t e;
    set_inputs(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h7, 32'h55, 5'd5, 32'h0020_82B3);
    sb_q.push_back('{rw: 1'b1, m2r: 1'b0, alu: 32'h7, md: 32'h0, rd: 5'd5, insn: 32'h0020_82B3});
    @(negedge clk);
    e = sb_q.pop_front();
    n_checks++; if (observe() !== e) $display("FAIL add_pass got %h exp %h", observe(), e); else n_pass++;
    n_checks++; if ({stall_out, dmem_req} !== 2'b00)
      $display("FAIL add_stall got %b exp 00", {stall_out, dmem_req});
    else n_pass++;
    @(posedge clk); #1;
    set_inputs(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h44, 32'h0, 5'd9, 32'hFFFF_FFFF);
    @(negedge clk);
    n_checks++; if (observe() !== {2'b00, 69'h0, Nop} || stall_out !== 1'b0)
      $display("FAIL invalid_bubble got %h stall %b exp %h stall 0", observe(), stall_out,
               {2'b00, 69'h0, Nop});
    else n_pass++;
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_lb();
    int st; res_t o, e; logic be_, ok, we, stb; logic [31:0] a, wd; logic [3:0] be;
    set_inputs(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 32'h203, 32'h0, 5'd7, 32'h0030_0383);
    sb_q.push_back(model(1'b1, 1'b1, 1'b1, 3'b000, 32'h203, 5'd7, 32'h0030_0383,
                         32'h80FF_1234, 1'b0));
    wait_done(1, 32'h80FF_1234, st, o, be_, ok, a, be, we, wd, stb);
    clear_inputs();
    e = sb_q.pop_front();
    n_checks++; if (!ok) $display("FAIL lb_done got none exp done"); else n_pass++;
    n_checks++; if ({a, be, we} !== {32'h200, 4'b1111, 1'b0})
      $display("FAIL lb_bus got %h/%b/%b exp 00000200/1111/0", a, be, we);
    else n_pass++;
    n_checks++; if (st !== 2) $display("FAIL lb_stalls got %0d exp 2", st); else n_pass++;
    n_checks++; if (o !== e) $display("FAIL lb_result got %h exp %h", o, e); else n_pass++;
    n_checks++; if (o.md !== 32'hFFFF_FF80) $display("FAIL lb_data got %h exp ffffff80", o.md); else n_pass++;
  endtask

  task automatic test_sh();
    int st; res_t o, e; logic be_, ok, we, stb; logic [31:0] a, wd; logic [3:0] be;
    set_inputs(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 32'h42, 32'h0000_ABCD, 5'd0, 32'h00A1_1123);
    sb_q.push_back(model(1'b0, 1'b0, 1'b0, 3'b001, 32'h42, 5'd0, 32'h00A1_1123, 32'h0, 1'b0));
    wait_done(1, 32'hFFFF_FFFF, st, o, be_, ok, a, be, we, wd, stb);
    clear_inputs();
    e = sb_q.pop_front();
    n_checks++; if ({a, be, we, wd} !== {32'h40, 4'b1100, 1'b1, 32'hABCD_ABCD})
      $display("FAIL sh_bus got %h/%b/%b/%h exp 00000040/1100/1/abcdabcd", a, be, we, wd);
    else n_pass++;
    n_checks++; if (!ok || o !== e) $display("FAIL sh_result got %h exp %h", o, e); else n_pass++;
  endtask

  task automatic test_misaligned();
    res_t e;
    logic [2:0]  f3s[3]   = '{3'b010, 3'b011, 3'b100};
    logic        mws[3]   = '{1'b0, 1'b0, 1'b1};
    logic [31:0] addrs[3] = '{32'h101, 32'h100, 32'h100};
    for (int i = 0; i < 3; i++) begin
      set_inputs(1'b1, ~mws[i], mws[i], ~mws[i], ~mws[i], f3s[i], addrs[i], 32'h1, 5'd4,
                 32'h0000_1003);
      sb_q.push_back('{rw: 1'b0, m2r: 1'b0, alu: 32'h0, md: 32'h0, rd: 5'd0, insn: Nop});
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++; if ({misaligned_out, dmem_req, stall_out} !== 3'b100)
        $display("FAIL mis_flags%0d got mis/req/stall %b exp 100", i,
                 {misaligned_out, dmem_req, stall_out});
      else n_pass++;
      n_checks++; if (observe() !== e) $display("FAIL mis_bubble%0d got %h exp %h", i, observe(), e);
      else n_pass++;
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      n_checks++; if ({misaligned_out, dmem_req} !== 2'b00)
        $display("FAIL mis_pulse%0d got mis/req %b exp 00", i, {misaligned_out, dmem_req});
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ack_delay();
    int st; res_t o, e; logic be_, ok, we, stb; logic [31:0] a, wd; logic [3:0] be;
    set_inputs(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b101, 32'h106, 32'h0, 5'd12, 32'h0063_5603);
    sb_q.push_back(model(1'b1, 1'b1, 1'b1, 3'b101, 32'h106, 5'd12, 32'h0063_5603,
                         32'hBEEF_1234, 1'b0));
    wait_done(5, 32'hBEEF_1234, st, o, be_, ok, a, be, we, wd, stb);
    clear_inputs();
    e = sb_q.pop_front();
    n_checks++; if (st !== 6) $display("FAIL delay_stalls got %0d exp 6", st); else n_pass++;
    n_checks++; if (stb !== 1'b1) $display("FAIL delay_stable got %b exp 1", stb); else n_pass++;
    n_checks++; if (!ok || o !== e || be_ !== 1'b0)
      $display("FAIL delay_result got %h err %b exp %h err 0", o, be_, e);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int st; res_t o, e; logic be_, ok, we, stb; logic [31:0] a, wd; logic [3:0] be;
    set_inputs(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h300, 32'h0, 5'd9, 32'h0001_2483);
    sb_q.push_back(model(1'b1, 1'b1, 1'b1, 3'b010, 32'h300, 5'd9, 32'h0001_2483,
                         32'h1111_1111, 1'b1));
    wait_done(0, 32'h1111_1111, st, o, be_, ok, a, be, we, wd, stb);
    clear_inputs();
    e = sb_q.pop_front();
    n_checks++; if (st !== 17) $display("FAIL to_stalls got %0d exp 17", st); else n_pass++;
    n_checks++; if (be_ !== 1'b1) $display("FAIL to_buserr got %b exp 1", be_); else n_pass++;
    n_checks++; if (!ok || o !== e) $display("FAIL to_result got %h exp %h", o, e); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus_err_out !== 1'b0) $display("FAIL to_pulse got %b exp 0", bus_err_out); else n_pass++;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic mr; logic mw; logic [2:0] f3; logic [31:0] addr; logic [31:0] sd;
    logic [4:0] rd; logic [31:0] rdata; logic [3:0] be; logic [31:0] wdata;
  } op_t;

  task automatic test_back_to_back();
    int st; res_t o, e; logic be_, ok, we, stb; logic [31:0] a, wd; logic [3:0] be;
    op_t ops[6];
    ops[0] = '{1'b1, 1'b0, 3'b100, 32'h1001, 32'h0, 5'd1, 32'h1122_3344, 4'b1111, 32'h0};
    ops[1] = '{1'b1, 1'b0, 3'b001, 32'h1002, 32'h0, 5'd2, 32'h8001_0000, 4'b1111, 32'h0};
    ops[2] = '{1'b1, 1'b0, 3'b010, 32'h1004, 32'h0, 5'd0, 32'hDEAD_BEEF, 4'b1111, 32'h0};
    ops[3] = '{1'b0, 1'b1, 3'b000, 32'h1011, 32'h1234_565A, 5'd3, 32'h0, 4'b0010, 32'h5A5A_5A5A};
    ops[4] = '{1'b0, 1'b1, 3'b010, 32'h1020, 32'hCAFE_F00D, 5'd4, 32'h0, 4'b1111, 32'hCAFE_F00D};
    ops[5] = '{1'b1, 1'b0, 3'b000, 32'h1000, 32'h0, 5'd6, 32'h0000_007F, 4'b1111, 32'h0};
    for (int i = 0; i < 6; i++) begin
      set_inputs(1'b1, ops[i].mr, ops[i].mw, ops[i].mr, ops[i].mr, ops[i].f3, ops[i].addr,
                 ops[i].sd, ops[i].rd, 32'h0000_0003 + (i << 12));
      sb_q.push_back(model(ops[i].mr, ops[i].mr, ops[i].mr, ops[i].f3, ops[i].addr, ops[i].rd,
                           32'h0000_0003 + (i << 12), ops[i].rdata, 1'b0));
      wait_done(1, ops[i].rdata, st, o, be_, ok, a, be, we, wd, stb);
      e = sb_q.pop_front();
      n_checks++; if (!ok || o !== e || st !== 2)
        $display("FAIL b2b_result%0d got %h stalls %0d exp %h stalls 2", i, o, st, e);
      else n_pass++;
      n_checks++; if (a !== {ops[i].addr[31:2], 2'b00} || be !== ops[i].be || we !== ops[i].mw ||
                      (ops[i].mw && wd !== ops[i].wdata))
        $display("FAIL b2b_bus%0d got %h/%b/%b/%h exp %h/%b/%b/%h", i, a, be, we, wd,
                 {ops[i].addr[31:2], 2'b00}, ops[i].be, ops[i].mw, ops[i].wdata);
      else n_pass++;
    end
    clear_inputs();
  endtask

  task automatic test_stray_ack();
    dmem_ack = 1'b1;
    @(negedge clk);
    n_checks++; if ({stall_out, dmem_req} !== 2'b00)
      $display("FAIL stray_ack got stall/req %b exp 00", {stall_out, dmem_req});
    else n_pass++;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    n_checks++; if ({stall_out, dmem_req, RegWrite_out} !== 3'b000)
      $display("FAIL stray_ack_after got %b exp 000", {stall_out, dmem_req, RegWrite_out});
    else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_lb();
    test_sh();
    test_misaligned();
    test_ack_delay();
    test_timeout();
    test_back_to_back();
    test_stray_ack();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
